// File: rtl/sdram_local_master.sv
// Local-side SDRAM traffic master: writes an address-derived pattern, reads it back in order and counts mismatches.
// Requests are driven combinationally from registered state and held until local_ready; read issue throttles on outstanding words.
module sdram_local_master #(
    parameter int MAX_BURST       = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic        phy_clk,
    input  logic        reset_phy_clk_n,
    input  logic        status_init_done,
    input  logic        cmd_start,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic [23:0] first_err_addr,
    input  logic        local_ready,
    output logic        local_write_req,
    output logic        local_read_req,
    output logic [23:0] local_address,
    output logic [2:0]  local_size,
    output logic        local_burstbegin,
    output logic [1:0]  local_be,
    output logic [15:0] local_wdata,
    input  logic [15:0] local_rdata,
    input  logic        local_rdata_valid
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = OW + 3;
    localparam logic [15:0] PATTERN = 16'hA5A5;

    typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_BURST, RD_REQ, RD_DRAIN, DONE} state_t;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] rem;
    } xfer_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    xfer_t         wr_q, wr_d;
    xfer_t         rd_q, rd_d;
    logic [2:0]    beat_q, beat_d;
    logic [23:0]   exp_addr_q, exp_addr_d;
    logic [OW-1:0] out_q, out_d;
    logic [15:0]   err_q, err_d;
    logic [23:0]   first_q, first_d;

    logic [2:0]    wr_size;
    logic [2:0]    rd_size;
    logic [23:0]   beat_addr;
    logic          rd_room;
    logic          wr_acc;
    logic          rd_acc;
    logic          rvalid;
    logic          last_beat;

    function automatic logic [2:0] burst_size(input logic [15:0] rem);
        if (rem >= 16'(MAX_BURST)) begin
            return 3'(MAX_BURST);
        end
        return rem[2:0];
    endfunction

    always_comb begin
        wr_size   = burst_size(wr_q.rem);
        rd_size   = burst_size(rd_q.rem);
        beat_addr = wr_q.addr + 24'(beat_q);
        last_beat = (beat_q == (wr_size - 3'd1));
        // A read burst may only go out if every word it asks for still fits in the return window.
        rd_room   = (CW'(out_q) + CW'(rd_size)) <= CW'(MAX_OUTSTANDING);

        local_write_req  = (state_q == WR_BURST);
        local_read_req   = (state_q == RD_REQ) && rd_room;
        local_address    = '0;
        local_size       = '0;
        local_be         = '0;
        local_wdata      = '0;
        if (state_q == WR_BURST) begin
            local_address = wr_q.addr;
            local_size    = wr_size;
            local_be      = 2'b11;
            local_wdata   = beat_addr[15:0] ^ PATTERN;
        end else if (state_q == RD_REQ) begin
            local_address = rd_q.addr;
            local_size    = rd_size;
        end
        local_burstbegin = (local_write_req && (beat_q == 3'd0)) || local_read_req;

        wr_acc = local_write_req && local_ready;
        rd_acc = local_read_req && local_ready;
        rvalid = local_rdata_valid && (out_q != '0);

        busy           = (state_q != IDLE);
        done           = (state_q == DONE);
        err_count      = err_q;
        first_err_addr = first_q;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        beat_d     = beat_q;
        exp_addr_d = exp_addr_q;
        err_d      = err_q;
        first_d    = first_q;

        out_d = out_q + (rd_acc ? OW'(rd_size) : '0) - (rvalid ? OW'(1) : '0);

        if (rvalid) begin
            exp_addr_d = exp_addr_q + 24'd1;
            if (local_rdata != (exp_addr_q[15:0] ^ PATTERN)) begin
                if (err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
                if (err_q == 16'd0) begin
                    first_d = exp_addr_q;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    state_d    = WAIT_INIT;
                    op_d       = cmd_op;
                    wr_d.addr  = cmd_addr;
                    wr_d.rem   = cmd_len;
                    rd_d.addr  = cmd_addr;
                    rd_d.rem   = cmd_len;
                    beat_d     = 3'd0;
                    exp_addr_d = cmd_addr;
                    err_d      = 16'd0;
                    first_d    = 24'd0;
                end
            end
            WAIT_INIT: begin
                if (status_init_done) begin
                    if (wr_q.rem == 16'd0) begin
                        state_d = DONE;
                    end else if (!op_q[0]) begin
                        state_d = WR_BURST;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WR_BURST: begin
                if (wr_acc) begin
                    if (last_beat) begin
                        beat_d    = 3'd0;
                        wr_d.addr = wr_q.addr + 24'(wr_size);
                        wr_d.rem  = wr_q.rem - 16'(wr_size);
                        if (wr_q.rem == 16'(wr_size)) begin
                            // The read cursor was loaded at command accept and is untouched by writes.
                            state_d = op_q[1] ? RD_REQ : DONE;
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            RD_REQ: begin
                if (rd_acc) begin
                    rd_d.addr = rd_q.addr + 24'(rd_size);
                    rd_d.rem  = rd_q.rem - 16'(rd_size);
                    if (rd_q.rem == 16'(rd_size)) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (out_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (!reset_phy_clk_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            beat_q     <= '0;
            exp_addr_q <= '0;
            out_q      <= '0;
            err_q      <= '0;
            first_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            beat_q     <= beat_d;
            exp_addr_q <= exp_addr_d;
            out_q      <= out_d;
            err_q      <= err_d;
            first_q    <= first_d;
        end
    end

endmodule

// File: tb/tb_sdram_local_master.sv
// Directed bench for sdram_local_master: command table plus reset corner sequences,
// with a bus responder that stores writes and returns read data after a programmable latency.
module tb_sdram_local_master;

    logic        phy_clk = 1'b0;
    logic        reset_phy_clk_n;
    logic        status_init_done;
    logic        cmd_start;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;
    logic        local_ready;
    logic        local_write_req;
    logic        local_read_req;
    logic [23:0] local_address;
    logic [2:0]  local_size;
    logic        local_burstbegin;
    logic [1:0]  local_be;
    logic [15:0] local_wdata;
    logic [15:0] local_rdata = 16'h0;
    logic        local_rdata_valid = 1'b0;

    always #5 phy_clk = ~phy_clk;

    sdram_local_master #(.MAX_BURST(4), .MAX_OUTSTANDING(16)) dut (
        .phy_clk          (phy_clk),
        .reset_phy_clk_n  (reset_phy_clk_n),
        .status_init_done (status_init_done),
        .cmd_start        (cmd_start),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .busy             (busy),
        .done             (done),
        .err_count        (err_count),
        .first_err_addr   (first_err_addr),
        .local_ready      (local_ready),
        .local_write_req  (local_write_req),
        .local_read_req   (local_read_req),
        .local_address    (local_address),
        .local_size       (local_size),
        .local_burstbegin (local_burstbegin),
        .local_be         (local_be),
        .local_wdata      (local_wdata),
        .local_rdata      (local_rdata),
        .local_rdata_valid(local_rdata_valid)
    );

    typedef struct {
        logic [23:0] addr;
        logic [2:0]  size;
        logic        bb;
        logic [1:0]  be;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        logic [23:0] addr;
        logic [2:0]  size;
    } rdb_t;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [15:0] len;
        bit          toggle;
        int          init_delay;
        bit          poke;
        int          lat;
        logic [23:0] bad_lo;
        int          bad_cnt;
        logic [15:0] exp_err;
        logic [23:0] exp_first;
        int          exp_peak;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder state
    logic [15:0] mem [logic [23:0]];
    beat_t       wlog[$];
    rdb_t        rdlog[$];
    int          ret_due[$];
    logic [15:0] ret_dat[$];
    int          lat = 5;
    logic [23:0] bad_lo = 24'h0;
    int          bad_cnt = 0;
    int          cyc = 0;
    int          w_cnt = 0;
    int          ret_cnt = 0;
    int          done_cnt = 0;
    int          w_at_done = 0;
    int          ret_at_done = 0;
    int          stab_seen = 0;
    int          stab_viol = 0;
    int          tb_out = 0;
    int          peak = 0;
    int          last_due = 0;
    logic [23:0] wbase = 24'h0;
    int          widx = 0;
    bit          pend = 1'b0;
    logic [47:0] saved = '0;

    function automatic logic [15:0] pat(input logic [23:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge phy_clk) begin
        logic [47:0] cur;
        logic [23:0] a;
        logic [23:0] off;
        logic [15:0] d;
        beat_t       b;
        rdb_t        r;
        int          due;
        cyc++;
        cur = {local_write_req, local_read_req, local_address, local_size,
               local_burstbegin, local_be, local_wdata};
        if (pend) begin
            stab_seen++;
            if (cur !== saved) stab_viol++;
        end
        pend  = reset_phy_clk_n && (local_write_req || local_read_req) && !local_ready;
        saved = cur;
        if (done) begin
            done_cnt++;
            w_at_done   = w_cnt;
            ret_at_done = ret_cnt;
        end
        if (reset_phy_clk_n && local_write_req && local_ready) begin
            if (local_burstbegin) begin
                wbase = local_address;
                widx  = 0;
            end
            mem[wbase + 24'(widx)] = local_wdata;
            b.addr = local_address; b.size = local_size; b.bb = local_burstbegin;
            b.be = local_be; b.wdata = local_wdata;
            wlog.push_back(b);
            w_cnt++;
            widx++;
        end
        if (reset_phy_clk_n && local_read_req && local_ready) begin
            r.addr = local_address; r.size = local_size;
            rdlog.push_back(r);
            tb_out += int'(local_size);
            for (int i = 0; i < int'(local_size); i++) begin
                a   = local_address + 24'(i);
                d   = mem.exists(a) ? mem[a] : pat(a);
                off = a - bad_lo;
                if (bad_cnt > 0 && int'(off) < bad_cnt) d = d ^ 16'h0100;
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                ret_due.push_back(due);
                ret_dat.push_back(d);
            end
        end
        if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
            local_rdata_valid = 1'b1;
            local_rdata       = ret_dat.pop_front();
            void'(ret_due.pop_front());
            ret_cnt++;
            tb_out--;
        end else begin
            local_rdata_valid = 1'b0;
            local_rdata       = 16'h0;
        end
        if (tb_out > peak) peak = tb_out;
    end

    task automatic run_vec(input vec_t v);
        int    d0, w0, r0, sv0, ss0, nw, nb, len_i, bs;
        bit    seen;
        beat_t b;
        rdb_t  r;
        logic [23:0] a, ba;
        lat = v.lat; bad_lo = v.bad_lo; bad_cnt = v.bad_cnt;
        for (int i = 0; i < 50 && busy; i++) begin
            @(posedge phy_clk); #1;
        end
        wlog.delete(); rdlog.delete();
        peak = 0;
        d0 = done_cnt; w0 = w_cnt; r0 = ret_cnt; sv0 = stab_viol; ss0 = stab_seen;
        cmd_start = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_len = v.len;
        status_init_done = (v.init_delay == 0);
        local_ready = 1'b1;
        @(posedge phy_clk); #1;
        cmd_start = 1'b0;
        chk("busy_on_accept", 64'(busy), 64'd1);
        if (v.init_delay > 0) begin
            repeat (v.init_delay) begin
                @(posedge phy_clk); #1;
            end
            chk("init_hold_reqs", 64'(wlog.size() + rdlog.size()), 64'd0);
            chk("init_hold_busy", 64'(busy), 64'd1);
            status_init_done = 1'b1;
        end
        seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
            @(posedge phy_clk); #1;
            local_ready = v.toggle ? ~local_ready : 1'b1;
            cmd_start   = v.poke && (c == 3);
            if (cmd_start) begin
                cmd_op = 2'b01; cmd_addr = 24'hABCDEF; cmd_len = 16'd2;
            end
        end
        cmd_start = 1'b0;
        local_ready = 1'b1;
        chk("done_seen", 64'(seen), 64'd1);
        repeat (4) begin
            @(posedge phy_clk); #1;
        end
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);

        len_i = int'(v.len);
        nw = (v.op[0] == 1'b0) ? len_i : 0;
        nb = (v.op == 2'b00 || len_i == 0) ? 0 : (len_i + 3) / 4;
        chk("wr_beats", 64'(wlog.size()), 64'(nw));
        chk("wr_beats_before_done", 64'(w_at_done - w0), 64'(nw));
        for (int k = 0; k < imin(nw, wlog.size()); k++) begin
            b  = wlog[k];
            a  = v.addr + 24'(k);
            ba = v.addr + 24'(4 * (k / 4));
            bs = imin(4, len_i - 4 * (k / 4));
            chk("wr_beat", 64'({b.addr, b.size, b.bb, b.be, b.wdata}),
                64'({ba, 3'(bs), (k % 4) == 0, 2'b11, pat(a)}));
        end
        chk("rd_bursts", 64'(rdlog.size()), 64'(nb));
        chk("rd_words_before_done", 64'(ret_at_done - r0), 64'((nb > 0) ? len_i : 0));
        for (int j = 0; j < imin(nb, rdlog.size()); j++) begin
            r = rdlog[j];
            chk("rd_burst", 64'({r.addr, r.size}),
                64'({v.addr + 24'(4 * j), 3'(imin(4, len_i - 4 * j))}));
        end
        chk("err_count", 64'(err_count), 64'(v.exp_err));
        chk("first_err_addr", 64'(first_err_addr), 64'(v.exp_first));
        chk("peak_outstanding", 64'(peak), 64'(v.exp_peak));
        chk("stall_stability", 64'(stab_viol - sv0), 64'd0);
        if (v.toggle) chk("stall_exercised", 64'(stab_seen > ss0), 64'd1);
    endtask

    vec_t tbl[10];
    vec_t fv;
    int   r0;
    bit   hit;

    initial begin
        reset_phy_clk_n  = 1'b0;
        status_init_done = 1'b0;
        cmd_start        = 1'b0;
        cmd_op           = 2'b00;
        cmd_addr         = 24'h0;
        cmd_len          = 16'h0;
        local_ready      = 1'b1;

        repeat (3) @(posedge phy_clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_reqs", 64'({local_write_req, local_read_req, local_burstbegin}), 64'd0);
        chk("rst_addr_size", 64'({local_address, local_size}), 64'd0);
        chk("rst_be_wdata", 64'({local_be, local_wdata}), 64'd0);
        chk("rst_err", 64'({err_count, first_err_addr}), 64'd0);
        reset_phy_clk_n = 1'b1;
        @(posedge phy_clk); #1;

        //         op     addr          len    tog   dly  poke  lat  bad_lo        cnt  err     first         peak
        tbl[0] = '{2'b00, 24'h000100, 16'd6,  1'b0, 0,  1'b0, 5,  24'h000000, 0, 16'd0, 24'h000000, 0};
        tbl[1] = '{2'b10, 24'h000200, 16'd8,  1'b0, 0,  1'b1, 5,  24'h000000, 0, 16'd0, 24'h000000, 8};
        tbl[2] = '{2'b01, 24'h000100, 16'd6,  1'b0, 0,  1'b0, 5,  24'h000102, 1, 16'd1, 24'h000102, 6};
        tbl[3] = '{2'b00, 24'h000300, 16'd5,  1'b1, 0,  1'b0, 5,  24'h000000, 0, 16'd0, 24'h000000, 0};
        tbl[4] = '{2'b00, 24'hFFFFFE, 16'd4,  1'b0, 10, 1'b0, 5,  24'h000000, 0, 16'd0, 24'h000000, 0};
        tbl[5] = '{2'b00, 24'h000500, 16'd0,  1'b0, 0,  1'b0, 5,  24'h000000, 0, 16'd0, 24'h000000, 0};
        tbl[6] = '{2'b11, 24'h000104, 16'd3,  1'b0, 0,  1'b0, 5,  24'h000105, 1, 16'd1, 24'h000105, 3};
        tbl[7] = '{2'b10, 24'hFFFFFD, 16'd5,  1'b1, 0,  1'b0, 5,  24'h000000, 0, 16'd0, 24'h000000, 5};
        tbl[8] = '{2'b01, 24'h000200, 16'd9,  1'b0, 0,  1'b0, 5,  24'h000203, 3, 16'd3, 24'h000203, 9};
        tbl[9] = '{2'b01, 24'h001000, 16'd32, 1'b0, 0,  1'b0, 20, 24'h000000, 0, 16'd0, 24'h000000, 16};

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i]);
        end

        // Reset while draining: three words still in flight must be dropped on return.
        lat = 20; bad_cnt = 0;
        rdlog.delete();
        cmd_start = 1'b1; cmd_op = 2'b01; cmd_addr = 24'h000400; cmd_len = 16'd3;
        status_init_done = 1'b1; local_ready = 1'b1;
        @(posedge phy_clk); #1;
        cmd_start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (rdlog.size() > 0) begin
                hit = 1'b1;
                break;
            end
            @(posedge phy_clk); #1;
        end
        chk("drain_read_issued", 64'(hit), 64'd1);
        repeat (3) begin
            @(posedge phy_clk); #1;
        end
        chk("drain_outstanding", 64'(tb_out), 64'd3);
        chk("drain_busy", 64'({busy, local_read_req}), 64'b10);
        r0 = ret_cnt;
        reset_phy_clk_n = 1'b0;
        @(posedge phy_clk); #1;
        chk("midrst_ctrl", 64'({busy, done, local_write_req, local_read_req, local_burstbegin,
                                local_address, local_size, local_be, local_wdata}), 64'd0);
        chk("midrst_err", 64'({err_count, first_err_addr}), 64'd0);
        reset_phy_clk_n = 1'b1;
        repeat (30) begin
            @(posedge phy_clk); #1;
        end
        chk("stale_words_returned", 64'(ret_cnt - r0), 64'd3);
        chk("stale_ignored_err", 64'(err_count), 64'd0);
        chk("stale_idle", 64'(busy), 64'd0);

        fv = '{2'b01, 24'h000400, 16'd1, 1'b0, 0, 1'b0, 5, 24'h000000, 0, 16'd0, 24'h000000, 1};
        run_vec(fv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_local_master.md
SDRAM_LOCAL_MASTER -- requirements
Module: sdram_local_master

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning maximum local_size per burst (legal values 1..4).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, meaning maximum read words requested but not yet returned.
REQ-003 SHALL have port phy_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_phy_clk_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port status_init_done  in  1  controller ready for traffic.
REQ-006 SHALL have port cmd_start  in  1  one-cycle command strobe.
REQ-007 SHALL have port cmd_op  in  2  00 write, 01 read-check, 10 write then read-check, 11 reserved (treated as 01).
REQ-008 SHALL have port cmd_addr  in  24  base word address.
REQ-009 SHALL have port cmd_len  in  16  transfer length in words.
REQ-010 SHALL have port busy  out  1  command in progress.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports err_count  out  16  (mismatch count) and first_err_addr  out  24  (address of first mismatch).
REQ-013 SHALL have port local_ready  in  1  controller accepts the current request beat.
REQ-014 SHALL have port local_write_req  out  1  write beat valid.
REQ-015 SHALL have port local_read_req  out  1  read burst request valid.
REQ-016 SHALL have ports local_address  out  24, local_size  out  3, local_burstbegin  out  1, local_be  out  2, local_wdata  out  16.
REQ-017 SHALL have ports local_rdata  in  16 and local_rdata_valid  in  1, carrying in-order read return data.

Function
REQ-018 SHALL implement states IDLE, WAIT_INIT, WR_BURST, RD_REQ, RD_DRAIN, DONE.
REQ-019 SHALL in IDLE latch cmd_op/cmd_addr/cmd_len on cmd_start and go to WAIT_INIT; cmd_start while busy=1 SHALL be ignored.
REQ-020 SHALL in WAIT_INIT issue no requests until status_init_done=1, then enter WR_BURST (op 00/10) or RD_REQ (op 01/11).
REQ-021 SHALL treat cmd_len=0 as a no-op: no requests issued, done pulses one cycle after leaving WAIT_INIT.
REQ-022 SHALL size each burst as min(MAX_BURST, remaining words).
REQ-023 SHALL hold any asserted request and its address/size/data/be/burstbegin stable until sampled with local_ready=1.
REQ-024 SHALL in WR_BURST drive local_write_req=1 for local_size beats; local_address and local_size SHALL stay constant across the burst; local_burstbegin=1 on the first beat only; local_be=2'b11.
REQ-025 SHALL drive local_wdata = addr[15:0] ^ 16'hA5A5, where addr is burst base address plus beat index.
REQ-026 SHALL, after the last write beat is accepted, go to DONE (op 00) or to RD_REQ restarting at the base address (op 10).
REQ-027 SHALL in RD_REQ assert local_read_req and local_burstbegin for one accepted beat per burst, advancing the address by local_size after acceptance.
REQ-028 SHALL not issue a read burst while outstanding + size > MAX_OUTSTANDING; outstanding increments by size on acceptance and decrements by 1 on each local_rdata_valid, both in the same cycle if simultaneous.
REQ-029 SHALL go to RD_DRAIN after the last read request is accepted, then to DONE when outstanding reaches 0.
REQ-030 SHALL compare each valid local_rdata against the REQ-025 pattern at the expected address (in-order counter); on mismatch increment err_count, saturating at 16'hFFFF, and record first_err_addr if err_count was 0.
REQ-031 SHALL ignore local_rdata_valid when outstanding=0.
REQ-032 SHALL wrap all address arithmetic modulo 2^24 (24'hFFFFFF + 1 -> 24'h000000), including bursts straddling the wrap.
REQ-033 SHALL in DONE pulse done=1 for one cycle and return to IDLE; busy=1 from the cycle after cmd_start accept through the DONE cycle.
REQ-034 SHALL clear err_count and first_err_addr on each accepted cmd_start.

Reset
REQ-035 SHALL on reset_phy_clk_n=0 at a clock edge enter IDLE with busy, done, local_write_req, local_read_req, local_burstbegin = 0, local_address=0, local_size=0, local_be=0, local_wdata=0, err_count=0, first_err_addr=0, outstanding=0.
REQ-036 SHALL on reset mid-command abandon the command; read data arriving after reset is ignored per REQ-031.

Verification
REQ-037 Write op 00, addr 0x000100, len 6, local_ready=1 -> bursts of size 4 and 2 at addresses 0x100 and 0x104, wdata 0xA4A5..0xA4A0, done after the 6th beat.
REQ-038 Op 10, len 8, model returns the written data after 5-cycle latency -> err_count=0, done pulses once after the 8th rdata_valid.
REQ-039 Op 01, model corrupts the word at 0x000102 -> err_count=1, first_err_addr=0x000102.
REQ-040 local_ready toggling 1-0-1 during a write burst -> no beat lost or duplicated, request fields stable while local_ready=0.
REQ-041 Addr 0xFFFFFE, len 4, op 00 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001 written with matching pattern; status_init_done=0 held 10 cycles first -> no request before it rises.
REQ-042 Reset asserted during RD_DRAIN with 3 words outstanding -> next cycle all outputs at reset values; a subsequent op 01 len 1 completes with err_count=0.
